// File: rtl/prog_clk_gen_if.sv
// Control and status bundle of the programmable clock generator.
// The master drives per-channel enable/load/values; the slave returns the generated waveforms.
interface prog_clk_gen_if #(
    parameter int CH = 2,
    parameter int W  = 8
);
    logic [CH-1:0]   en;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] period_in;
    logic [CH*W-1:0] high_in;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;

    modport master (
        output en, load, period_in, high_in,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, load, period_in, high_in,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/prog_clk_gen.sv
// Multi-channel programmable clock/strobe generator: per-channel period and high time
// in system-clock cycles, reloaded from a shadow only at period boundaries or when idle.
module prog_clk_gen #(
    parameter int CH = 2,
    parameter int W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    prog_clk_gen_if.slave  bus
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0]  per_q  [CH];
    logic [W-1:0]  hi_q   [CH];
    logic [W-1:0]  sper_q [CH];
    logic [W-1:0]  shi_q  [CH];
    logic [W-1:0]  cnt_q  [CH];
    logic [CH-1:0] run_q, pend_q, clk_q, tick_q;

    logic [W-1:0]  per_d  [CH];
    logic [W-1:0]  hi_d   [CH];
    logic [W-1:0]  sper_d [CH];
    logic [W-1:0]  shi_d  [CH];
    logic [W-1:0]  cnt_d  [CH];
    logic [CH-1:0] run_d, pend_d, clk_d, tick_d;

    function automatic logic [W-1:0] next_cnt(input logic [W-1:0] cnt, input logic at_end);
        return at_end ? '0 : cnt + ONE;
    endfunction

    always_comb begin
        for (int i = 0; i < CH; i++) begin : g_ch
            logic         at_end;
            logic         apply;
            logic [W-1:0] p_new;
            logic [W-1:0] h_new;
            logic [W-1:0] c_run;

            at_end = (cnt_q[i] == per_q[i] - ONE);
            // Shadow takes effect only when no period is in flight past this edge.
            apply  = pend_q[i] && (!run_q[i] || !bus.en[i] || at_end);
            p_new  = apply ? sper_q[i] : per_q[i];
            h_new  = apply ? shi_q[i]  : hi_q[i];
            c_run  = next_cnt(cnt_q[i], at_end);

            per_d[i]  = p_new;
            hi_d[i]   = h_new;
            sper_d[i] = bus.load[i] ? bus.period_in[i*W +: W] : sper_q[i];
            shi_d[i]  = bus.load[i] ? bus.high_in[i*W +: W]   : shi_q[i];
            // A load coinciding with an application lands in the shadow and stays pending.
            pend_d[i] = bus.load[i] | (pend_q[i] & ~apply);

            run_d[i]  = 1'b0;
            cnt_d[i]  = '0;
            clk_d[i]  = 1'b0;
            tick_d[i] = 1'b0;
            if (!bus.en[i] || p_new == '0) begin
                run_d[i]  = 1'b0;
            end else if (!run_q[i]) begin
                run_d[i]  = 1'b1;
                tick_d[i] = 1'b1;
                clk_d[i]  = (h_new != '0);
            end else begin
                run_d[i]  = 1'b1;
                cnt_d[i]  = c_run;
                tick_d[i] = (c_run == '0);
                clk_d[i]  = (c_run < h_new);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                per_q[i]  <= '0;
                hi_q[i]   <= '0;
                sper_q[i] <= '0;
                shi_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            run_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                per_q[i]  <= per_d[i];
                hi_q[i]   <= hi_d[i];
                sper_q[i] <= sper_d[i];
                shi_q[i]  <= shi_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            run_q  <= run_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pend_q;
endmodule

// File: tb/tb_prog_clk_gen.sv
// Bench for prog_clk_gen: directed vector table, hand-written corner sequences,
// and randomized traffic against a position-in-period reference model.
module tb_prog_clk_gen;
    localparam int CH = 2;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_clk_gen_if #(.CH(CH), .W(W)) bus ();
    prog_clk_gen #(.CH(CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pos = cycles since period start, -1 when idle.
    int mp [CH];
    int mh [CH];
    int sp [CH];
    int sh [CH];
    int pos[CH];
    bit mpend[CH];

    typedef struct {
        bit         rst;
        bit [1:0]   en;
        bit [1:0]   load;
        bit [W-1:0] p0, h0, p1, h1;
        bit [1:0]   eclk, etick, epend;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input bit r, input bit [1:0] e, input bit [1:0] l,
                                input int p0, input int h0, input int p1, input int h1,
                                input bit [1:0] c, input bit [1:0] t, input bit [1:0] pd);
        vec_t v;
        v.rst = r; v.en = e; v.load = l;
        v.p0 = W'(p0); v.h0 = W'(h0); v.p1 = W'(p1); v.h1 = W'(h1);
        v.eclk = c; v.etick = t; v.epend = pd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                mp[i] = 0; mh[i] = 0; sp[i] = 0; sh[i] = 0; mpend[i] = 0; pos[i] = -1;
            end else begin
                int np, nh, oldp;
                bit app;
                oldp = mp[i];
                app  = mpend[i] && (pos[i] < 0 || !bus.en[i] || pos[i] == oldp - 1);
                np   = app ? sp[i] : mp[i];
                nh   = app ? sh[i] : mh[i];
                if (bus.load[i]) begin
                    sp[i] = int'(bus.period_in[i*W +: W]);
                    sh[i] = int'(bus.high_in[i*W +: W]);
                    mpend[i] = 1;
                end else if (app) begin
                    mpend[i] = 0;
                end
                mp[i] = np;
                mh[i] = nh;
                if (!bus.en[i] || np == 0) pos[i] = -1;
                else if (pos[i] < 0)       pos[i] = 0;
                else                       pos[i] = (pos[i] + 1) % oldp;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < CH; i++) begin
            check($sformatf("model_clk%0d", i), bus.clk_out[i], (pos[i] >= 0 && pos[i] < mh[i]));
            check($sformatf("model_tick%0d", i), bus.tick[i], (pos[i] == 0));
            check($sformatf("model_pend%0d", i), bus.pending[i], mpend[i]);
        end
    endtask

    task automatic setup(input int ch, input int p, input int h);
        bus.en[ch] = 1'b0;
        bus.load[ch] = 1'b1;
        bus.period_in[ch*W +: W] = W'(p);
        bus.high_in[ch*W +: W]   = W'(h);
        cyc();
        check("setup_pend_set", bus.pending[ch], 1);
        bus.load[ch] = 1'b0;
        cyc();
        check("setup_pend_clr", bus.pending[ch], 0);
        bus.en[ch] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            mp[i] = 0; mh[i] = 0; sp[i] = 0; sh[i] = 0; mpend[i] = 0; pos[i] = -1;
        end
        bus.en = '0; bus.load = '0; bus.period_in = '0; bus.high_in = '0;

        //             rst en     load   p0 h0 p1 h1 clk    tick   pend
        tbl[0]  = mk(1, 2'b11, 2'b11, 5, 3, 5, 3, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(1, 2'b11, 2'b11, 5, 3, 5, 3, 2'b00, 2'b00, 2'b00);
        tbl[2]  = mk(1, 2'b11, 2'b11, 5, 3, 5, 3, 2'b00, 2'b00, 2'b00);
        tbl[3]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[4]  = mk(0, 2'b00, 2'b01, 3, 1, 0, 0, 2'b00, 2'b00, 2'b01);
        tbl[5]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[6]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
        tbl[7]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[8]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[9]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
        tbl[10] = mk(0, 2'b01, 2'b01, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01);
        tbl[11] = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        tbl[12] = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
        tbl[13] = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
        tbl[14] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[15] = mk(0, 2'b00, 2'b10, 0, 0, 0, 5, 2'b00, 2'b00, 2'b10);
        tbl[16] = mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        tbl[17] = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);

        for (int r = 0; r < 18; r++) begin
            rst           = tbl[r].rst;
            bus.en        = tbl[r].en;
            bus.load      = tbl[r].load;
            bus.period_in = {tbl[r].p1, tbl[r].p0};
            bus.high_in   = {tbl[r].h1, tbl[r].h0};
            cyc();
            check($sformatf("tbl%0d_clk", r),  bus.clk_out, tbl[r].eclk);
            check($sformatf("tbl%0d_tick", r), bus.tick,    tbl[r].etick);
            check($sformatf("tbl%0d_pend", r), bus.pending, tbl[r].epend);
        end
        bus.en = '0; bus.load = '0;

        // Basic P=10 H=7 waveform.
        setup(0, 10, 7);
        for (int k = 0; k < 30; k++) begin
            cyc();
            check("basic_clk",  bus.clk_out[0], ((k % 10) < 7));
            check("basic_tick", bus.tick[0],    ((k % 10) == 0));
        end

        // Reload P=4 H=2 mid-period; current period must finish intact.
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("reload_pre_clk", bus.clk_out[0], (k < 7));
        end
        bus.load[0] = 1'b1;
        bus.period_in[0 +: W] = W'(4);
        bus.high_in[0 +: W]   = W'(2);
        for (int k = 4; k < 10; k++) begin
            cyc();
            bus.load[0] = 1'b0;
            check("reload_old_clk",  bus.clk_out[0], (k < 7));
            check("reload_old_tick", bus.tick[0],    0);
            check("reload_pend",     bus.pending[0], 1);
        end
        for (int j = 0; j < 8; j++) begin
            cyc();
            check("reload_new_clk",  bus.clk_out[0], ((j % 4) < 2));
            check("reload_new_tick", bus.tick[0],    ((j % 4) == 0));
            check("reload_pend_clr", bus.pending[0], 0);
        end

        // Boundaries.
        setup(0, 5, 0);
        for (int j = 0; j < 10; j++) begin
            cyc();
            check("h0_clk",  bus.clk_out[0], 0);
            check("h0_tick", bus.tick[0],    ((j % 5) == 0));
        end
        setup(0, 5, 9);
        for (int j = 0; j < 10; j++) begin
            cyc();
            check("hbig_clk", bus.clk_out[0], 1);
        end
        setup(0, 1, 1);
        for (int j = 0; j < 5; j++) begin
            cyc();
            check("p1_tick", bus.tick[0], 1);
        end
        setup(0, 0, 3);
        for (int j = 0; j < 5; j++) begin
            cyc();
            check("p0_clk",  bus.clk_out[0], 0);
            check("p0_tick", bus.tick[0],    0);
        end

        // Enable drop, re-enable, then reset mid-high.
        setup(0, 10, 7);
        for (int k = 0; k < 5; k++) cyc();
        bus.en[0] = 1'b0;
        cyc();
        check("endrop_clk",  bus.clk_out[0], 0);
        check("endrop_tick", bus.tick[0],    0);
        bus.en[0] = 1'b1;
        cyc();
        check("enrise_clk",  bus.clk_out[0], 1);
        check("enrise_tick", bus.tick[0],    1);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("rstmid_clk",  bus.clk_out[0], 0);
        check("rstmid_pend", bus.pending[0], 0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            check("postrst_clk",  bus.clk_out[0], 0);
            check("postrst_tick", bus.tick[0],    0);
        end

        // Two channels together; ch1 reload must not disturb ch0.
        bus.en = '0;
        bus.load = 2'b11;
        bus.period_in = {W'(8), W'(3)};
        bus.high_in   = {W'(4), W'(1)};
        cyc();
        bus.load = '0;
        cyc();
        bus.en = 2'b11;
        for (int k = 0; k < 24; k++) begin
            if (k == 5) begin
                bus.load[1] = 1'b1;
                bus.period_in[W +: W] = W'(6);
                bus.high_in[W +: W]   = W'(3);
            end else begin
                bus.load[1] = 1'b0;
            end
            cyc();
            check("ind_clk0",  bus.clk_out[0], ((k % 3) < 1));
            check("ind_tick0", bus.tick[0],    ((k % 3) == 0));
            check("ind_clk1",  bus.clk_out[1], (k < 8) ? ((k % 8) < 4) : (((k - 8) % 6) < 3));
            check("ind_tick1", bus.tick[1],    (k < 8) ? (k == 0) : (((k - 8) % 6) == 0));
            check("ind_pend1", bus.pending[1], (k >= 5 && k < 8));
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < CH; i++) begin
                bus.en[i]   = ($urandom_range(0, 9) != 0);
                bus.load[i] = ($urandom_range(0, 7) == 0);
                bus.period_in[i*W +: W] = W'($urandom_range(0, 12));
                bus.high_in[i*W +: W]   = W'($urandom_range(0, 14));
            end
            cyc();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prog_clk_gen.md
# prog_clk_gen

Synthesisable, multi-channel programmable clock/waveform generator. It is the parametrised successor of the behavioural frequency/duty testbench clock. Each channel produces a registered periodic waveform whose period and high time are integer counts of the system clock. Period and high time are reloaded glitch-free at period boundaries. Used on-chip as a divided-clock/strobe source and in benches as a cycle-exact stimulus generator.

## Interface
- CH, default 2: number of independent channels.
- W, default 8: width of period/high-time counts; max period 2^W-1 cycles.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  CH  per-channel run enable.
- load  input  CH  per-channel strobe; captures period_in/high_in slice into shadow.
- period_in  input  CH*W  channel i period at [i*W +: W], in clk cycles.
- high_in  input  CH*W  channel i high time at [i*W +: W], in clk cycles.
- clk_out  output  CH  registered generated waveform per channel.
- tick  output  CH  one-cycle pulse on the first cycle of each period.
- pending  output  CH  shadow holds values not yet applied.

## Operation
- Per channel state:
  - active period P and active high time H;
  - shadow period/high;
  - pending flag;
  - run flag;
  - W-bit counter cnt.
- Reset (rst=1 at edge): all of P, H, shadow, cnt, run, pending, clk_out and tick are 0. Reset overrides all other inputs, including mid-period.
- load[i]=1: shadow <= slice values and pending <= 1. A later load before application overwrites the shadow.
- Application of the shadow (P,H <= shadow; pending <= 0) happens at an edge where either:
  - the channel is idle (run=0 after that edge), or
  - the channel wraps (run=1, en=1, cnt==P-1).
- A load sampled at the same edge as an application goes to the shadow only. It applies at the next boundary, and pending stays 1.
- Idle: en=0 or P==0. At that edge: run<=0, cnt<=0, clk_out<=0, tick<=0.
- Start: run=0, en=1, P>0 (P after any application at this edge). At that edge: run<=1, cnt<=0, tick<=1, clk_out<=(H>0).
- Running: cnt<= (cnt==P-1) ? 0 : cnt+1. tick<= (new cnt==0). clk_out<= (new cnt < new H).
- Waveform: high for H cycles, then low for P-H cycles, with period P.
- Boundaries:
  - H=0: constant low, ticks still generated.
  - H>=P: constant high.
  - P=1: cnt stays 0, tick high every cycle.
  - P=0: channel idle regardless of en.
- Channels are fully independent. No combinational path from inputs to outputs.

## Timing
- All outputs are flops.
- clk_out rises in the same cycle tick is asserted (period start).
- en rising, sampled at edge k, puts the first period start in the cycle after edge k.
- en falling, sampled at edge k, forces clk_out and tick low in the cycle after edge k, with no partial-period completion.
- Reload latency is up to P cycles (the next wrap), or 1 edge when idle. The waveform never shows a truncated or stretched period.
- Counter compare is unsigned, W bits. cnt never exceeds P-1.

## Test plan
- Reset values: assert rst for 3 cycles with en=all-1, load=all-1 → clk_out=0, tick=0, pending=0 throughout. After release with en=0, outputs stay 0.
- Basic waveform: ch0, load P=10 H=7 while idle, then en=1 → pending clears 1 edge after load. Waveform is 7 cycles high, 3 low, repeating, with tick every 10 cycles coincident with each rising clk_out.
- Glitch-free reload: ch0 running P=10 H=7; load P=4 H=2 at cnt=3 → pending=1 until the wrap. The current period completes as 7 high/3 low, then 2 high/2 low from the next tick.
- Boundaries:
  - H=0, P=5 → clk_out constant 0, tick every 5 cycles.
  - H=9, P=5 → clk_out constant 1.
  - P=1 → tick every cycle.
  - P=0 with en=1 → all outputs 0.
- Enable/reset mid-operation: drop en at cnt=4 of P=10 → outputs 0 next cycle. Re-raise en → fresh period starting at cnt=0. Assert rst mid-high → clk_out=0 next cycle and P,H cleared.
- Channel independence: ch0 P=3 H=1 and ch1 P=8 H=4 run together → both waveforms exact over 24 cycles. A load on ch1 leaves ch0 unaffected.
